// File: rtl/ext_code_sequencer.sv
// Code page sequencer: stores DEPTH host-written pages and plays them out,
// highest index first, one page per synchronized external trigger.
module ext_code_sequencer #(
  parameter int CODE_W = 32,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3,
  parameter int HOLD_W = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iSET_CODE_FLAG,
  input  logic [CODE_W-1:0] iSET_CODE,
  input  logic              iSET_INDEX_FLAG,
  input  logic [IDX_W-1:0]  iSET_INDEX,
  input  logic              iSET_HOLD_FLAG,
  input  logic [HOLD_W-1:0] iSET_HOLD,
  input  logic              iLOOP,
  input  logic              iARM,
  input  logic              iABORT,
  input  logic              iCLR_ERR,
  input  logic              iTrigger,
  output logic [CODE_W-1:0] oCode,
  output logic [IDX_W-1:0]  oIndex,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErrWrite,
  output logic              oErrMissed
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_OUTPUT, S_DONE} state_t;

  state_t            r_state, w_state_next;
  logic [CODE_W-1:0] r_mem [DEPTH];
  logic [CODE_W-1:0] r_code, w_code_next;
  logic [IDX_W-1:0]  r_index, w_index_next, r_start;
  logic [HOLD_W-1:0] r_hold, r_cnt, w_cnt_next;
  logic              r_sync0, r_sync1, r_sync2, r_trig_p;
  logic              r_err_write, r_err_missed;
  logic              w_host_ok, w_wr_en, w_any_wr;
  logic              w_set_err_write, w_set_err_missed;

  assign w_host_ok        = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_wr_en          = w_host_ok && !iABORT;
  assign w_any_wr         = iSET_CODE_FLAG || iSET_INDEX_FLAG || iSET_HOLD_FLAG;
  assign w_set_err_write  = w_any_wr && !w_host_ok;
  assign w_set_err_missed = r_trig_p && (r_state == S_OUTPUT);

  // Two-flop synchronizer plus a registered edge detector: trig_p lands on edge 3.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_sync0  <= 1'b0;
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_trig_p <= 1'b0;
    end else begin
      r_sync0  <= iTrigger;
      r_sync1  <= r_sync0;
      r_sync2  <= r_sync1;
      r_trig_p <= r_sync1 && !r_sync2;
    end
  end

  // Page storage is deliberately left out of reset.
  always_ff @(posedge iClk) begin
    if (w_wr_en && iSET_CODE_FLAG) begin
      r_mem[iSET_INDEX] <= iSET_CODE;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_start <= '0;
      r_hold  <= HOLD_W'(1);
    end else if (w_wr_en) begin
      if (iSET_INDEX_FLAG) r_start <= iSET_INDEX;
      if (iSET_HOLD_FLAG)  r_hold  <= (iSET_HOLD == '0) ? HOLD_W'(1) : iSET_HOLD;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_err_write  <= 1'b0;
      r_err_missed <= 1'b0;
    end else begin
      if (w_set_err_write)       r_err_write  <= 1'b1;
      else if (iCLR_ERR)         r_err_write  <= 1'b0;
      if (w_set_err_missed)      r_err_missed <= 1'b1;
      else if (iCLR_ERR)         r_err_missed <= 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state <= S_IDLE;
      r_index <= '0;
      r_cnt   <= '0;
      r_code  <= '0;
    end else begin
      r_state <= w_state_next;
      r_index <= w_index_next;
      r_cnt   <= w_cnt_next;
      r_code  <= w_code_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    w_cnt_next   = r_cnt;
    w_code_next  = '0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (iARM) begin
          w_state_next = S_ARMED;
          w_index_next = r_start;
        end
      end
      S_ARMED: begin
        if (r_trig_p) begin
          w_state_next = S_OUTPUT;
          w_code_next  = r_mem[r_index];
          w_cnt_next   = r_hold - HOLD_W'(1);
        end
      end
      S_OUTPUT: begin
        // The page stays up while cnt counts down; it drops on the cnt==0 edge.
        if (r_cnt != '0) begin
          w_cnt_next  = r_cnt - HOLD_W'(1);
          w_code_next = r_code;
        end else if (r_index != '0) begin
          w_index_next = r_index - IDX_W'(1);
          w_state_next = S_ARMED;
        end else if (iLOOP) begin
          w_index_next = r_start;
          w_state_next = S_ARMED;
        end else begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_wr_en && iSET_INDEX_FLAG) begin
      w_index_next = iSET_INDEX;
    end
    if (iABORT) begin
      w_state_next = S_IDLE;
      w_code_next  = '0;
      w_index_next = r_start;
    end
  end

  assign oCode      = r_code;
  assign oIndex     = r_index;
  assign oBusy      = (r_state == S_ARMED) || (r_state == S_OUTPUT);
  assign oDone      = (r_state == S_DONE);
  assign oErrWrite  = r_err_write;
  assign oErrMissed = r_err_missed;

endmodule

// File: tb/tb_ext_code_sequencer.sv
// Directed bench for ext_code_sequencer: playback order, hold timing, looping,
// error flags, abort and asynchronous reset.
module tb_ext_code_sequencer;
  localparam int CODE_W = 32;
  localparam int DEPTH  = 8;
  localparam int IDX_W  = 3;
  localparam int HOLD_W = 16;

  logic              iClk = 1'b0;
  logic              iRst = 1'b0;
  logic              iSET_CODE_FLAG = 1'b0;
  logic [CODE_W-1:0] iSET_CODE = '0;
  logic              iSET_INDEX_FLAG = 1'b0;
  logic [IDX_W-1:0]  iSET_INDEX = '0;
  logic              iSET_HOLD_FLAG = 1'b0;
  logic [HOLD_W-1:0] iSET_HOLD = '0;
  logic              iLOOP = 1'b0;
  logic              iARM = 1'b0;
  logic              iABORT = 1'b0;
  logic              iCLR_ERR = 1'b0;
  logic              iTrigger = 1'b0;
  logic [CODE_W-1:0] oCode;
  logic [IDX_W-1:0]  oIndex;
  logic              oBusy, oDone, oErrWrite, oErrMissed;

  int checks = 0;
  int errors = 0;

  ext_code_sequencer #(.CODE_W(CODE_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .HOLD_W(HOLD_W)) dut (
    .iClk(iClk), .iRst(iRst),
    .iSET_CODE_FLAG(iSET_CODE_FLAG), .iSET_CODE(iSET_CODE),
    .iSET_INDEX_FLAG(iSET_INDEX_FLAG), .iSET_INDEX(iSET_INDEX),
    .iSET_HOLD_FLAG(iSET_HOLD_FLAG), .iSET_HOLD(iSET_HOLD),
    .iLOOP(iLOOP), .iARM(iARM), .iABORT(iABORT), .iCLR_ERR(iCLR_ERR),
    .iTrigger(iTrigger),
    .oCode(oCode), .oIndex(oIndex), .oBusy(oBusy), .oDone(oDone),
    .oErrWrite(oErrWrite), .oErrMissed(oErrMissed)
  );

  always #5 iClk = ~iClk;

  // All tasks start and end right at a falling edge; inputs change there.
  task automatic wr_page(input logic [IDX_W-1:0] idx, input logic [CODE_W-1:0] data);
    iSET_CODE_FLAG = 1'b1; iSET_INDEX = idx; iSET_CODE = data;
    @(negedge iClk);
    iSET_CODE_FLAG = 1'b0;
  endtask

  task automatic wr_index(input logic [IDX_W-1:0] idx);
    iSET_INDEX_FLAG = 1'b1; iSET_INDEX = idx;
    @(negedge iClk);
    iSET_INDEX_FLAG = 1'b0;
  endtask

  task automatic wr_hold(input logic [HOLD_W-1:0] h);
    iSET_HOLD_FLAG = 1'b1; iSET_HOLD = h;
    @(negedge iClk);
    iSET_HOLD_FLAG = 1'b0;
  endtask

  task automatic pulse_arm();
    iARM = 1'b1; @(negedge iClk); iARM = 1'b0;
  endtask

  task automatic pulse_abort();
    iABORT = 1'b1; @(negedge iClk); iABORT = 1'b0;
  endtask

  task automatic pulse_clr();
    iCLR_ERR = 1'b1; @(negedge iClk); iCLR_ERR = 1'b0;
  endtask

  // One trigger: page must appear 4 edges later, last exactly `hold` clocks, then drop.
  task automatic fire(input logic [CODE_W-1:0] exp, input int hold);
    iTrigger = 1'b1;
    @(negedge iClk); iTrigger = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    checks++;
    if (oCode !== '0) begin
      errors++; $display("FAIL pre_output: oCode=%h expected 0", oCode);
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge iClk);
      checks++;
      if (oCode !== exp) begin
        errors++; $display("FAIL hold_cycle%0d: oCode=%h expected %h", k, oCode, exp);
      end
    end
    @(negedge iClk);
    checks++;
    if (oCode !== '0) begin
      errors++; $display("FAIL post_hold: oCode=%h expected 0", oCode);
    end
    $display("trigger: page %h held %0d clocks, index now %0d", exp, hold, oIndex);
  endtask

  task automatic test_reset();
    iRst = 1'b0;
    repeat (2) @(negedge iClk);
    checks++;
    if ({oCode, oIndex, oBusy, oDone, oErrWrite, oErrMissed} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: code=%h idx=%0d busy=%b done=%b ew=%b em=%b expected all 0",
               oCode, oIndex, oBusy, oDone, oErrWrite, oErrMissed);
    end
    iRst = 1'b1;
    @(negedge iClk);
    $display("test_reset done");
  endtask

  task automatic test_single_shot();
    wr_page(3'd0, 32'h11); wr_page(3'd1, 32'h22); wr_page(3'd2, 32'h33); wr_page(3'd3, 32'h44);
    wr_index(3'd3); wr_hold(16'd4); iLOOP = 1'b0;
    pulse_arm();
    checks++;
    if (oBusy !== 1'b1 || oIndex !== 3'd3) begin
      errors++; $display("FAIL armed: busy=%b idx=%0d expected 1/3", oBusy, oIndex);
    end
    fire(32'h44, 4); fire(32'h33, 4); fire(32'h22, 4); fire(32'h11, 4);
    checks++;
    if (oDone !== 1'b1 || oBusy !== 1'b0) begin
      errors++; $display("FAIL single_done: done=%b busy=%b expected 1/0", oDone, oBusy);
    end
    $display("test_single_shot done");
  endtask

  task automatic test_loop();
    iLOOP = 1'b1;
    pulse_arm();
    fire(32'h44, 4); fire(32'h33, 4); fire(32'h22, 4); fire(32'h11, 4);
    fire(32'h44, 4); fire(32'h33, 4);
    checks++;
    if (oDone !== 1'b0 || oBusy !== 1'b1 || oIndex !== 3'd1) begin
      errors++; $display("FAIL loop_state: done=%b busy=%b idx=%0d expected 0/1/1", oDone, oBusy, oIndex);
    end
    iLOOP = 1'b0;
    pulse_abort();
    $display("test_loop done");
  endtask

  task automatic test_missed();
    wr_hold(16'd10);
    pulse_arm();
    iTrigger = 1'b1;
    @(negedge iClk); iTrigger = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    for (int k = 0; k < 10; k++) begin
      @(negedge iClk);
      checks++;
      if (oCode !== 32'h44) begin
        errors++; $display("FAIL missed_hold%0d: oCode=%h expected 44", k, oCode);
      end
      if (k == 2) iTrigger = 1'b1;
      if (k == 3) iTrigger = 1'b0;
    end
    @(negedge iClk);
    checks++;
    if (oCode !== '0 || oErrMissed !== 1'b1 || oIndex !== 3'd2 || oBusy !== 1'b1) begin
      errors++;
      $display("FAIL missed_flag: code=%h em=%b idx=%0d busy=%b expected 0/1/2/1",
               oCode, oErrMissed, oIndex, oBusy);
    end
    repeat (4) @(negedge iClk);
    checks++;
    if (oCode !== '0) begin
      errors++; $display("FAIL missed_dropped: oCode=%h expected 0", oCode);
    end
    pulse_abort();
    $display("test_missed done");
  endtask

  task automatic test_write_error();
    wr_index(3'd0); wr_hold(16'd2);
    pulse_clr();
    pulse_arm();
    wr_page(3'd0, 32'hFFFF);
    checks++;
    if (oErrWrite !== 1'b1 || oErrMissed !== 1'b0) begin
      errors++; $display("FAIL write_err_set: ew=%b em=%b expected 1/0", oErrWrite, oErrMissed);
    end
    fire(32'h11, 2);
    checks++;
    if (oDone !== 1'b1) begin
      errors++; $display("FAIL write_err_done: done=%b expected 1", oDone);
    end
    pulse_clr();
    checks++;
    if (oErrWrite !== 1'b0) begin
      errors++; $display("FAIL write_err_clear: ew=%b expected 0", oErrWrite);
    end
    $display("test_write_error done");
  endtask

  task automatic test_abort();
    wr_page(3'd5, 32'h55); wr_page(3'd4, 32'h66);
    wr_index(3'd5); wr_hold(16'd4);
    pulse_arm();
    fire(32'h55, 4);
    iTrigger = 1'b1;
    @(negedge iClk); iTrigger = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    repeat (2) begin
      @(negedge iClk);
      checks++;
      if (oCode !== 32'h66 || oIndex !== 3'd4) begin
        errors++; $display("FAIL abort_pre: code=%h idx=%0d expected 66/4", oCode, oIndex);
      end
    end
    pulse_abort();
    checks++;
    if (oCode !== '0 || oIndex !== 3'd5 || oBusy !== 1'b0 || oDone !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: code=%h idx=%0d busy=%b done=%b expected 0/5/0/0",
               oCode, oIndex, oBusy, oDone);
    end
    $display("test_abort done");
  endtask

  task automatic test_hold_zero();
    wr_hold(16'd0);
    pulse_arm();
    fire(32'h55, 1);
    checks++;
    if (oIndex !== 3'd4 || oBusy !== 1'b1) begin
      errors++; $display("FAIL hold_zero: idx=%0d busy=%b expected 4/1", oIndex, oBusy);
    end
    pulse_abort();
    $display("test_hold_zero done");
  endtask

  task automatic test_async_reset();
    wr_index(3'd3); wr_hold(16'd4);
    pulse_arm();
    wr_hold(16'd7);
    iTrigger = 1'b1;
    @(negedge iClk); iTrigger = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    @(negedge iClk);
    checks++;
    if (oCode !== 32'h44 || oErrWrite !== 1'b1) begin
      errors++; $display("FAIL rst_pre: code=%h ew=%b expected 44/1", oCode, oErrWrite);
    end
    #2 iRst = 1'b0;
    #1;
    checks++;
    if (oCode !== '0 || oBusy !== 1'b0) begin
      errors++; $display("FAIL rst_async: code=%h busy=%b expected 0/0", oCode, oBusy);
    end
    @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    checks++;
    if (oErrWrite !== 1'b0 || oErrMissed !== 1'b0 || oIndex !== 3'd0 || oDone !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: ew=%b em=%b idx=%0d done=%b expected 0/0/0/0",
               oErrWrite, oErrMissed, oIndex, oDone);
    end
    pulse_arm();
    fire(32'h11, 1);
    checks++;
    if (oDone !== 1'b1) begin
      errors++; $display("FAIL rst_hold1_done: done=%b expected 1", oDone);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    @(negedge iClk);
    test_reset();
    test_single_shot();
    test_loop();
    test_missed();
    test_write_error();
    test_abort();
    test_hold_zero();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
